// File: rtl/operand_stage.sv
// ID-stage operand resolution and ID/EX pipeline register with load-use hazard detection.
// Optional feature macro: OPERAND_FORWARD_EN (forwarding from EX/MEM/WB; otherwise interlock only).
module operand_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_ra1,
  input  logic [2:0] id_ra2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic [2:0] id_wa,
  input  logic       id_we,
  input  logic       id_load,
  input  logic [3:0] id_alu_op,
  input  logic [7:0] id_imm,
  input  logic [7:0] rf_rd1,
  input  logic [7:0] rf_rd2,
  input  logic [7:0] ex_result,
  input  logic       mem_we,
  input  logic [2:0] mem_wa,
  input  logic [7:0] mem_data,
  input  logic       wb_we,
  input  logic [2:0] wb_wa,
  input  logic [7:0] wb_data,
  input  logic       flush,
  output logic       ex_valid,
  output logic [7:0] ex_a,
  output logic [7:0] ex_b,
  output logic [7:0] ex_imm,
  output logic [3:0] ex_alu_op,
  output logic [2:0] ex_wa,
  output logic       ex_we,
  output logic       ex_load,
  output logic       stall,
  output logic       id_ready
);

  logic [7:0] opa, opb;
  logic       hazard;

`ifdef OPERAND_FORWARD_EN
  // A load in ID/EX has no data yet, so it is never a forwarding source.
  logic ex_fwd_ok;
  assign ex_fwd_ok = ex_valid & ex_we & ~ex_load;

  always_comb begin
    opa = rf_rd1;
    if (ex_fwd_ok && (ex_wa == id_ra1))       opa = ex_result;
    else if (mem_we && (mem_wa == id_ra1))    opa = mem_data;
    else if (wb_we && (wb_wa == id_ra1))      opa = wb_data;
  end

  always_comb begin
    opb = rf_rd2;
    if (ex_fwd_ok && (ex_wa == id_ra2))       opb = ex_result;
    else if (mem_we && (mem_wa == id_ra2))    opb = mem_data;
    else if (wb_we && (wb_wa == id_ra2))      opb = wb_data;
  end

  always_comb begin
    hazard = 1'b0;
    if (id_valid && ex_valid && ex_load && ex_we) begin
      hazard = (id_use1 && (ex_wa == id_ra1)) || (id_use2 && (ex_wa == id_ra2));
    end
  end
`else
  logic ex_wr, dep1, dep2;
  logic unused_data;

  assign opa   = rf_rd1;
  assign opb   = rf_rd2;
  assign ex_wr = ex_valid & ex_we;
  // Without bypass paths, any in-flight writer of a used source must drain first.
  assign dep1  = id_use1 & ((ex_wr & (ex_wa == id_ra1)) | (mem_we & (mem_wa == id_ra1)) |
                            (wb_we & (wb_wa == id_ra1)));
  assign dep2  = id_use2 & ((ex_wr & (ex_wa == id_ra2)) | (mem_we & (mem_wa == id_ra2)) |
                            (wb_we & (wb_wa == id_ra2)));
  assign hazard = id_valid & (dep1 | dep2);
  assign unused_data = ^{ex_result, mem_data, wb_data};
`endif

  // Flush consumes the ID instruction, so it overrides any hazard.
  assign stall    = hazard & ~flush;
  assign id_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_we     <= 1'b0;
      ex_load   <= 1'b0;
      ex_a      <= 8'h00;
      ex_b      <= 8'h00;
      ex_imm    <= 8'h00;
      ex_alu_op <= 4'h0;
      ex_wa     <= 3'h0;
    end else if (flush || stall || !id_valid) begin
      ex_valid <= 1'b0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
    end else begin
      ex_valid  <= 1'b1;
      ex_we     <= id_we;
      ex_load   <= id_load;
      ex_a      <= opa;
      ex_b      <= opb;
      ex_imm    <= id_imm;
      ex_alu_op <= id_alu_op;
      ex_wa     <= id_wa;
    end
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have clock clk, input, 1 bit, rising-edge clock for all state.
REQ-002 The block SHALL have reset rst, input, 1 bit, synchronous, active-high.
REQ-003 The block SHALL have inputs id_valid (1), id_ra1 (3), id_ra2 (3), id_use1 (1), id_use2 (1), id_wa (3), id_we (1), id_load (1), id_alu_op (4) and id_imm (8): the decoded instruction in ID.
REQ-004 The block SHALL have inputs rf_rd1 (8) and rf_rd2 (8): the combinational register-file read data for id_ra1 and id_ra2.
REQ-005 The block SHALL have input ex_result (8): the combinational ALU result of the instruction currently held in the ID/EX register.
REQ-006 The block SHALL have inputs mem_we (1), mem_wa (3) and mem_data (8): the MEM-stage writer, with ALU result or load data.
REQ-007 The block SHALL have inputs wb_we (1), wb_wa (3) and wb_data (8): the WB-stage writer, also driving the register-file write port.
REQ-008 The block SHALL have input flush (1): branch redirect, kills the ID instruction.
REQ-009 The block SHALL have outputs ex_valid (1), ex_a (8), ex_b (8), ex_imm (8), ex_alu_op (4), ex_wa (3), ex_we (1) and ex_load (1), forming the registered ID/EX register.
REQ-010 The block SHALL have outputs stall (1) and id_ready (1), both combinational, with id_ready = ~stall.

Function
REQ-011 Each source operand SHALL be resolved by priority: ID/EX (ex_valid & ex_we & ~ex_load & ex_wa==ra) -> ex_result; else MEM (mem_we & mem_wa==ra) -> mem_data; else WB (wb_we & wb_wa==ra) -> wb_data; else rf_rdN.
REQ-012 Register 0 SHALL be an ordinary register, forwarded and hazard-checked like all others.
REQ-013 Load-use: stall SHALL be 1 when id_valid & ex_valid & ex_load & ex_we, and (id_use1 & ex_wa==id_ra1) or (id_use2 & ex_wa==id_ra2).
REQ-014 An operand with id_useN=0 SHALL never cause a stall.
REQ-015 On a clock edge with stall=1, the ID/EX register SHALL load a bubble (ex_valid=0, ex_we=0, ex_load=0); the remaining ex_* fields SHALL hold.
REQ-016 On a clock edge with id_valid=0, the ID/EX register SHALL load a bubble.
REQ-017 Otherwise, the ID/EX register SHALL capture the resolved operands and the id_* fields, with ex_valid=1, giving 1-cycle latency from ID to EX.
REQ-018 A flush SHALL force stall=0 and load a bubble on the same edge; the ID instruction is consumed (id_ready=1).
REQ-019 Edge-update priority SHALL be rst > flush > stall > id_valid.
REQ-020 A stall SHALL last exactly 1 cycle per load-use; afterwards, the load value SHALL be forwarded from mem_data.
REQ-021 The block SHALL perform no arithmetic; all data paths SHALL be 8 bits and all address compares 3 bits.

Reset
REQ-022 While rst=1 at an edge, the block SHALL set ex_valid, ex_we and ex_load to 0, and ex_a, ex_b, ex_imm, ex_alu_op and ex_wa to 0.
REQ-023 During and after reset, stall SHALL follow REQ-013 from the cleared state, so stall=0 in the first cycle after reset.
REQ-024 A reset asserted mid-stall SHALL cancel the stall, with no pending state retained.

Configuration
REQ-025 With OPERAND_FORWARD_EN defined, REQ-011 and REQ-013 SHALL apply.
REQ-026 Without OPERAND_FORWARD_EN, operands SHALL come only from rf_rdN.
REQ-027 Without OPERAND_FORWARD_EN, stall SHALL be 1 while any used source matches a valid writer in ID/EX (ex_valid & ex_we), MEM (mem_we) or WB (wb_we).
REQ-028 Without OPERAND_FORWARD_EN, REQ-015, REQ-018 and REQ-019 SHALL be unchanged.

Verification
REQ-029 Bench SHALL check EX forwarding: ID/EX holds ALU writer wa=3, ex_result=0x5A; ID ra1=3, use1=1, rf_rd1=0x00 -> next edge ex_a=0x5A, stall=0.
REQ-030 Bench SHALL check forwarding priority: MEM wa=2 data 0x11 and WB wa=2 data 0x22, ra2=2 -> ex_b=0x11.
REQ-031 Bench SHALL check load-use: ID/EX load wa=4; ID ra1=4 -> stall=1 for 1 cycle and a bubble; next cycle mem_data=0x77 -> ex_a=0x77, ex_valid=1.
REQ-032 Bench SHALL check flush over stall: a load-use condition plus flush=1 -> stall=0, id_ready=1, ex_valid=0 after the edge.
REQ-033 Bench SHALL check reset mid-stall: rst=1 during a load-use stall -> all ex_* outputs 0; next cycle stall=0.
REQ-034 Bench SHALL check the no-forward build: WB wa=1 writing, ID ra2=1 -> stall=1 for that cycle; next cycle ex_b=rf_rd2.
